// File: rtl/aes_pkg.sv
// Shared Rijndael helpers: byte type, per-row shift offsets and byte indexing.
package aes_pkg;

  typedef logic [7:0] byte_t;

  // Row offsets: {0,1,2,3} for NB = 4 or 6, {0,1,3,4} for NB = 8.
  function automatic int shift_off(input int nb, input int r);
    if (nb == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  // Column-major byte numbering: byte k sits at row k%4, column k/4.
  function automatic int byte_idx(input int r, input int c);
    return 4 * c + r;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for an NB-column state.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] state,
  input  logic             inv,
  output logic [32*NB-1:0] perm
);

  localparam int W = 32 * NB;

  logic [W-1:0] fwd;
  logic [W-1:0] bwd;

  // Source indices are resolved at elaboration; the hardware is pure wiring.
  for (genvar k = 0; k < 4 * NB; k++) begin : g_fwd
    localparam int R = k % 4;
    localparam int C = k / 4;
    localparam int S = byte_idx(R, (C + shift_off(NB, R)) % NB);
    assign fwd[W-1-8*k -: 8] = state[W-1-8*S -: 8];
  end

  for (genvar k = 0; k < 4 * NB; k++) begin : g_inv
    localparam int R = k % 4;
    localparam int C = k / 4;
    localparam int S = byte_idx(R, (C - shift_off(NB, R) + NB) % NB);
    assign bwd[W-1-8*k -: 8] = state[W-1-8*S -: 8];
  end

  assign perm = inv ? bwd : fwd;

endmodule

// File: rtl/shift_rows_pipe.sv
// Pipelined ShiftRows / InvShiftRows stage with valid/ready on both sides and a sideband tag.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB          = 4,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [32*NB-1:0]   in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [32*NB-1:0]   out_state,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (!(PIPE_STAGES == 1 || PIPE_STAGES == 2)) begin : g_bad_stages
    $error("shift_rows_pipe: PIPE_STAGES must be 1 or 2");
  end

  logic [W-1:0]             perm_state;
  logic [PIPE_STAGES-1:0]   v;
  logic [PIPE_STAGES-1:0]   load;
  logic [PIPE_STAGES-1:0]   up_v;
  logic [W-1:0]             data  [PIPE_STAGES];
  logic [TAG_W-1:0]         tag   [PIPE_STAGES];
  logic [W-1:0]             up_d  [PIPE_STAGES];
  logic [TAG_W-1:0]         up_t  [PIPE_STAGES];

  shift_rows_perm #(.NB(NB)) u_perm (
    .state (in_state),
    .inv   (in_inv),
    .perm  (perm_state)
  );

  // A stage can load if it or any stage after it is empty, or the output drains.
  always_comb begin
    load = '0;
    for (int i = 0; i < PIPE_STAGES; i++) begin
      load[i] = out_ready;
      for (int j = i; j < PIPE_STAGES; j++) begin
        load[i] = load[i] | ~v[j];
      end
    end
  end

  always_comb begin
    up_v    = '0;
    up_v[0] = in_valid;
    up_d[0] = perm_state;
    up_t[0] = in_tag;
    for (int i = 1; i < PIPE_STAGES; i++) begin
      up_v[i] = v[i-1];
      up_d[i] = data[i-1];
      up_t[i] = tag[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) begin
        data[i] <= '0;
        tag[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        if (flush) begin
          v[i] <= 1'b0;
        end else if (load[i]) begin
          v[i] <= up_v[i];
        end
        // Data only moves with a real beat, so a stalled output holds steady.
        if (!flush && load[i] && up_v[i]) begin
          data[i] <= up_d[i];
          tag[i]  <= up_t[i];
        end
      end
    end
  end

  assign in_ready  = ~flush & load[0];
  assign out_valid = v[PIPE_STAGES-1];
  assign out_state = data[PIPE_STAGES-1];
  assign out_tag   = tag[PIPE_STAGES-1];

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench: NB=4/1 stage, NB=6/1 stage, NB=8/2 stages with hand-computed vectors.
module tb_shift_rows_pipe;

  localparam logic [127:0] ID4   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] FWD4  = 128'h00050a0f_04090e03_080d0207_0c01060b;
  localparam logic [127:0] INV4  = 128'h000d0a07_04010e0b_0805020f_0c090603;
  localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [191:0] ID6   = 192'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617;
  localparam logic [191:0] FWD6  = 192'h00050a0f_04090e13_080d1217_0c111603_10150207_1401060b;
  localparam logic [255:0] ID8   = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
  localparam logic [255:0] FWD8  = 256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic         a_in_valid = 0, a_in_ready, a_in_inv = 0, a_out_valid, a_out_ready = 1;
  logic [3:0]   a_in_tag = 0, a_out_tag;
  logic [127:0] a_in_state = 0, a_out_state;
  logic         c_in_valid = 0, c_in_ready, c_in_inv = 0, c_out_valid, c_out_ready = 1;
  logic [3:0]   c_in_tag = 0, c_out_tag;
  logic [191:0] c_in_state = 0, c_out_state;
  logic         b_in_valid = 0, b_in_ready, b_in_inv = 0, b_out_valid, b_out_ready = 1;
  logic [3:0]   b_in_tag = 0, b_out_tag;
  logic [255:0] b_in_state = 0, b_out_state;

  shift_rows_pipe #(.NB(4), .PIPE_STAGES(1), .TAG_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_inv(a_in_inv), .in_tag(a_in_tag), .in_state(a_in_state), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_state(a_out_state), .out_tag(a_out_tag));

  shift_rows_pipe #(.NB(6), .PIPE_STAGES(1), .TAG_W(4)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_inv(c_in_inv), .in_tag(c_in_tag), .in_state(c_in_state), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_state(c_out_state), .out_tag(c_out_tag));

  shift_rows_pipe #(.NB(8), .PIPE_STAGES(2), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_inv(b_in_inv), .in_tag(b_in_tag), .in_state(b_in_state), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_state(b_out_state), .out_tag(b_out_tag));

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [127:0] s, input logic inv, input logic [3:0] t);
    a_in_valid = 1'b1; a_in_state = s; a_in_inv = inv; a_in_tag = t;
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic send6(input logic [191:0] s, input logic inv, input logic [3:0] t);
    c_in_valid = 1'b1; c_in_state = s; c_in_inv = inv; c_in_tag = t;
    tick();
    c_in_valid = 1'b0;
  endtask

  // Two-stage pipe: nothing may show after one clock, the beat shows after two.
  task automatic send8(input logic [255:0] s, input logic inv, input logic [3:0] t, input string nm);
    b_in_valid = 1'b1; b_in_state = s; b_in_inv = inv; b_in_tag = t;
    tick();
    b_in_valid = 1'b0;
    chk({nm, "_lat1"}, b_out_valid, 1'b0);
    tick();
    chk({nm, "_lat2"}, b_out_valid, 1'b1);
  endtask

  logic [191:0] r6, mid6;
  logic [255:0] r8, mid8, held, pat;
  int  occ, nin, nout;
  bit  stall_prev, in_x, out_x;

  initial begin
    // reset state
    #2;
    chk("rst_a_valid", a_out_valid, 1'b0);
    chk("rst_a_state", a_out_state, '0);
    chk("rst_a_ready", a_in_ready, 1'b1);
    chk("rst_b_valid", b_out_valid, 1'b0);
    chk("rst_b_tag",   b_out_tag, '0);
    #10 rst_n = 1'b1;
    tick();

    // NB=4 identity and FIPS-197 vectors
    send4(ID4, 1'b0, 4'h1);
    chk("n4_fwd_id_valid", a_out_valid, 1'b1);
    chk("n4_fwd_id", a_out_state, FWD4);
    chk("n4_fwd_id_tag", a_out_tag, 4'h1);
    send4(ID4, 1'b1, 4'h2);
    chk("n4_inv_id", a_out_state, INV4);
    send4(FIPS_IN, 1'b0, 4'h3);
    chk("n4_fips_fwd", a_out_state, FIPS_OUT);
    send4(FIPS_OUT, 1'b1, 4'h4);
    chk("n4_fips_inv", a_out_state, FIPS_IN);
    chk("n4_fips_inv_tag", a_out_tag, 4'h4);
    tick();
    chk("n4_drain", a_out_valid, 1'b0);

    // NB=6 identity and random round trip
    send6(ID6, 1'b0, 4'h0);
    chk("n6_fwd_id", c_out_state, FWD6);
    r6 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send6(r6, 1'b0, 4'd3);
    chk("n6_rt_tag3", c_out_tag, 4'd3);
    mid6 = c_out_state;
    send6(mid6, 1'b1, 4'd5);
    chk("n6_roundtrip", c_out_state, r6);
    chk("n6_rt_tag5", c_out_tag, 4'd5);
    tick();

    // NB=8 identity (row 3 moves 4 columns) and random round trip
    send8(ID8, 1'b0, 4'h6, "n8_id");
    chk("n8_fwd_id", b_out_state, FWD8);
    chk("n8_row3_c0", b_out_state[255-8*3 -: 8], 8'h13);
    chk("n8_row3_c4", b_out_state[255-8*19 -: 8], 8'h03);
    r8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send8(r8, 1'b0, 4'd3, "n8_rt1");
    chk("n8_rt_tag3", b_out_tag, 4'd3);
    mid8 = b_out_state;
    send8(mid8, 1'b1, 4'd5, "n8_rt2");
    chk("n8_roundtrip", b_out_state, r8);
    chk("n8_rt_tag5", b_out_tag, 4'd5);
    tick();
    chk("n8_drain", b_out_valid, 1'b0);

    // Stream of 8 beats with out_ready toggling; beat j is ID8 ^ (j*0x11 in every byte)
    occ = 0; nin = 0; nout = 0; stall_prev = 0; held = '0;
    for (int cyc = 0; cyc < 40 && nout < 8; cyc++) begin
      b_out_ready = (cyc % 2 == 0);
      b_in_valid  = (nin < 8);
      pat         = {32{8'(nin * 17)}};
      b_in_state  = ID8 ^ pat;
      b_in_inv    = 1'b0;
      b_in_tag    = 4'(nin);
      #1;
      chk("str_in_ready", b_in_ready, !(occ == 2 && !b_out_ready));
      if (stall_prev) begin
        chk("str_hold_valid", b_out_valid, 1'b1);
        chk("str_hold_state", b_out_state, held);
      end
      in_x  = b_in_valid && b_in_ready;
      out_x = b_out_valid && b_out_ready;
      if (out_x) begin
        pat = {32{8'(nout * 17)}};
        chk("str_state", b_out_state, FWD8 ^ pat);
        chk("str_tag", b_out_tag, 4'(nout));
        nout++;
      end
      stall_prev = b_out_valid && !b_out_ready;
      held = b_out_state;
      if (in_x) nin++;
      occ = occ + int'(in_x) - int'(out_x);
      tick();
    end
    b_in_valid = 1'b0;
    chk("str_count_in", nin, 8);
    chk("str_count_out", nout, 8);
    b_out_ready = 1'b1;
    tick();
    chk("str_empty", b_out_valid, 1'b0);

    // Flush with two beats in flight and a beat presented
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_state = ID8; b_in_tag = 4'h1;
    tick();
    b_in_state = ~ID8; b_in_tag = 4'h2;
    tick();
    chk("fl_full_valid", b_out_valid, 1'b1);
    chk("fl_full_ready", b_in_ready, 1'b0);
    b_out_ready = 1'b1;
    flush = 1'b1; b_in_state = r8; b_in_tag = 4'h3;
    #1;
    chk("fl_in_ready", b_in_ready, 1'b0);
    tick();
    flush = 1'b0; b_in_valid = 1'b0;
    chk("fl_cleared", b_out_valid, 1'b0);
    tick();
    chk("fl_dropped", b_out_valid, 1'b0);
    send8(ID8, 1'b0, 4'h9, "fl_next");
    chk("fl_next_state", b_out_state, FWD8);
    chk("fl_next_tag", b_out_tag, 4'h9);
    tick();

    // Asynchronous reset between edges
    a_out_ready = 1'b0;
    send4(ID4, 1'b0, 4'h7);
    chk("ar_pre_valid", a_out_valid, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid", a_out_valid, 1'b0);
    chk("ar_state", a_out_state, '0);
    chk("ar_tag", a_out_tag, '0);
    chk("ar_ready", a_in_ready, 1'b1);
    #1 rst_n = 1'b1;
    a_out_ready = 1'b1;
    tick();
    send4(FIPS_IN, 1'b0, 4'h8);
    chk("ar_resume_valid", a_out_valid, 1'b1);
    chk("ar_resume_state", a_out_state, FIPS_OUT);
    chk("ar_resume_tag", a_out_tag, 4'h8);
    tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
